// File: rtl/nios_security_pio_in.sv
// nios_security_pio_in: Avalon-MM input PIO with sync, edge capture, irq mask; debounce enabled by NIOS_SECURITY_PIO_IN_DEBOUNCE_EN
module nios_security_pio_in #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] deb_q, deb_d, mask_q, mask_d, cap_q, cap_d, edge_ev, raw, sel, clr;
  logic [31:0] readdata_q, readdata_d;
  logic wr;
  logic unused_wdata;
  assign unused_wdata = ^writedata;
  assign raw = sync_q[SYNC_STAGES-1];
  assign wr = chipselect & ~write_n;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
`ifdef NIOS_SECURITY_PIO_IN_DEBOUNCE_EN
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  // per-bit stability counter: deb only moves after CMAX+1 consecutive differing cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      deb_d[i] = cnt_q[i] == CMAX ? raw[i] : deb_q[i];
      cnt_d[i] = (raw[i] == deb_q[i]) || (cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
    end
  end
  // debounce counter state
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  assign deb_d = raw;
`endif
  // edge detection on the debounced value, register updates and read mux
  always_comb begin
    edge_ev = EDGE_MODE == 0 ? deb_d & ~deb_q : EDGE_MODE == 1 ? ~deb_d & deb_q : deb_d ^ deb_q;
    clr = wr && address == 2'd2 ? writedata[WIDTH-1:0] : '0;
    cap_d = (cap_q & ~clr) | edge_ev;
    mask_d = wr && address == 2'd1 ? writedata[WIDTH-1:0] : mask_q;
    sel = address == 2'd0 ? deb_q : address == 2'd1 ? mask_q : address == 2'd2 ? cap_q : raw;
    readdata_d = 32'(sel);
  end
  // all state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      deb_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end
  assign readdata = readdata_q;
  assign irq = |(cap_q & mask_q);
endmodule

// File: doc/nios_security_pio_in.md
Name: nios_security_pio_in

Overview:
- Parametrised Avalon-MM input PIO, the successor to the fixed 16-bit switch-read port on the Nios security subsystem.
- Adds the following over the plain read port:
  - input synchroniser
  - per-bit debounce (optional)
  - edge-capture register with write-1-to-clear
  - per-bit interrupt mask and a level IRQ to the Nios
- Sits between board switches/buttons/status lines and the Avalon interconnect.

Parameters:
- WIDTH, 16: number of input bits; legal range 1..32.
- SYNC_STAGES, 2: flip-flop synchroniser depth; legal range >=2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a debounced bit changes; legal range >=1.
- EDGE_MODE, 0: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1: system clock.
- reset  in  1: reset.
- address  in  2: register select.
- chipselect  in  1: slave select; qualifies writes only.
- write_n  in  1: active-low write strobe.
- writedata  in  32: write data.
- readdata  out  32: registered read data.
- in_port  in  WIDTH: asynchronous external inputs.
- irq  out  1: level interrupt to the Nios.

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Register map. Readdata bits above WIDTH read 0.
  - Address 0, DATA (RO): debounced input value.
  - Address 1, IRQMASK (RW): bits [WIDTH-1:0]; 1 = bit enabled for irq.
  - Address 2, EDGECAP (RW1C): a 1 written to a bit clears that bit; writing 0 has no effect.
  - Address 3, RAW (RO): synchroniser output, before debounce.
- Read timing:
  - readdata <= mux(address) on every clk, independent of chipselect.
  - Latency is 1 cycle: data for the address presented in cycle N appears in cycle N+1.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. Writes to addresses 0 and 3 are ignored.
- Synchroniser: sync[SYNC_STAGES-1] reflects in_port exactly SYNC_STAGES clocks after in_port is sampled.
- Debounce, per bit with its own counter sized to hold DEBOUNCE_CYCLES-1:
  - If sync == deb: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: deb <= sync, counter <= 0.
  - Else: counter <= counter + 1.
  - Net effect: deb follows a change only after DEBOUNCE_CYCLES consecutive differing cycles. Any glitch shorter than that resets the counter and leaves deb unchanged.
- Edge capture:
  - An edge event is a deb bit transition matching EDGE_MODE.
  - The EDGECAP bit sets on the same clk edge on which deb updates.
  - Bits stay set until cleared by software.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- irq = |(EDGECAP & IRQMASK), derived combinationally from the two registers.
  - irq asserts the cycle after the capture bit or mask bit becomes 1.
  - irq deasserts the cycle after the clear.
  - Changing IRQMASK never alters EDGECAP.
- End-to-end latency: an in_port change appears in deb, and in EDGECAP, SYNC_STAGES + DEBOUNCE_CYCLES clocks after it is first sampled.
- Reset (while reset=1):
  - readdata, IRQMASK, EDGECAP, sync chain, deb, all counters = 0; irq = 0.
  - Reset mid-debounce discards the count.
  - An input held high through reset produces a rising edge event SYNC_STAGES + DEBOUNCE_CYCLES clocks after reset falls.
- With WIDTH=32, all register bits are implemented and no padding is applied.

Optional Feature:
- Macro: NIOS_SECURITY_PIO_IN_DEBOUNCE_EN.
- Defined: debounce counters are present as described above.
- Undefined:
  - No counters are instantiated.
  - deb = sync[SYNC_STAGES-1], registered one stage, so DATA latency is SYNC_STAGES + 1.
  - DEBOUNCE_CYCLES is ignored.
  - All other behaviour is unchanged.

Test Plan:
1. Reset release, DATA read: WIDTH=16, DEBOUNCE_CYCLES=4, in_port=16'h0000, release reset, read address 0 -> readdata=32'h0 one cycle after the address; irq=0.
2. Debounce delay and glitch rejection: in_port 16'h0000->16'h00A5, held -> DATA=32'h000000A5 exactly 2+4 clocks later; RAW=32'h000000A5 after 2 clocks. A 3-cycle pulse 16'h0100 -> DATA and EDGECAP unchanged.
3. Edge capture and irq: EDGE_MODE=0, write IRQMASK=32'h1, in_port bit0 rises and is held -> EDGECAP=32'h1, irq=1 on the following cycle. Write 32'h1 to address 2 -> EDGECAP=0, irq=0 next cycle.
4. Set/clear collision: EDGECAP write-1-clear of bit3 on the same clk as a new bit3 rising edge -> EDGECAP bit3 remains 1 and irq stays asserted if masked.
5. Masking: EDGECAP=32'h0000_0006, IRQMASK=0 -> irq=0. Write IRQMASK=32'h4 -> irq=1 next cycle. Write IRQMASK=0 -> irq=0, EDGECAP still reads 32'h6.
6. Macro off, EDGE_MODE=2, WIDTH=8: in_port toggles 8'h00->8'hFF->8'h00 with 5-cycle holds -> DATA tracks with SYNC_STAGES+1 latency and EDGECAP=32'hFF after the first toggle. Reset asserted mid-sequence -> all registers 0 on the next clk.
